// File: rtl/unidade_controle_fsm_pkg.sv
// ---------------------------------------------------------------------------
// unidade_controle_fsm_pkg
// Shared definitions for the processor control unit: opcode constants for the
// {opcode, X, Y} instruction layout and the T-step encoding that the unit
// exposes on its Tstep output.
// ---------------------------------------------------------------------------
package unidade_controle_fsm_pkg;

  // Opcodes (3-bit reference encoding; widened/narrowed by the top to OP_BITS)
  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MVNZ = 3'b110;

  // T-step encoding, visible directly on Tstep
  typedef enum logic [1:0] {
    T0 = 2'b00,
    T1 = 2'b01,
    T2 = 2'b10,
    T3 = 2'b11
  } step_t;

endpackage

// File: rtl/unidade_controle_fsm_decode_n_onehot.sv
// ---------------------------------------------------------------------------
// decode_n_onehot
// Binary-to-one-hot decoder with enable. A select value with no matching
// output bit (i_sel >= NUM_REGS) yields an all-zero result.
// Ports:
//   i_en      enable; 0 forces all outputs low
//   i_sel     SEL_BITS binary select
//   o_onehot  NUM_REGS one-hot result
// ---------------------------------------------------------------------------
module decode_n_onehot #(
  parameter int SEL_BITS = 3,
  parameter int NUM_REGS = 8
) (
  input  logic                i_en,
  input  logic [SEL_BITS-1:0] i_sel,
  output logic [NUM_REGS-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      o_onehot[i] = i_en && (i_sel == SEL_BITS'(i));
    end
  end

endmodule

// File: rtl/unidade_controle_fsm.sv
// ---------------------------------------------------------------------------
// unidade_controle_fsm
// Control unit for the simple bus processor. Runs its own T0..T3 step
// sequence, decodes {opcode, X, Y} instructions (mv, mvi, add, sub, mvnz,
// everything else a NOP) and drives the datapath enables. Counts retired
// instructions.
//
// Start/complete protocol: Run is a request sampled only in T0; when Run=1
// in T0 the instruction is fetched (IRin/DINout) and then always runs to
// completion. Done marks the last step; the following edge returns to T0 and
// bumps InstrCount. Run held high gives back-to-back instructions.
//
// Ports:
//   Clock, Resetn         clock, async active-low reset
//   Run                   start request
//   Instrucao             IR contents {opcode, X, Y}
//   GNZ                   G non-zero flag
//   IRin, DINout          fetch / immediate bus drive
//   Rin, Rout             one-hot register write / bus-drive enables
//   Ain, Gin, Gout        accumulator and result register controls
//   AddSub                ALU mode (0 add, 1 sub)
//   Done                  last step of the current instruction
//   Tstep                 current step (state register, for observation)
//   InstrCount            retired instruction count (wraps)
// ---------------------------------------------------------------------------
module unidade_controle_fsm
  import unidade_controle_fsm_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int SEL_BITS = 3,
  parameter int OP_BITS  = 3,
  parameter int CNT_BITS = 16
) (
  input  logic                          Clock,
  input  logic                          Resetn,
  input  logic                          Run,
  input  logic [OP_BITS+2*SEL_BITS-1:0] Instrucao,
  input  logic                          GNZ,
  output logic                          IRin,
  output logic                          DINout,
  output logic [NUM_REGS-1:0]           Rin,
  output logic [NUM_REGS-1:0]           Rout,
  output logic                          Ain,
  output logic                          Gin,
  output logic                          Gout,
  output logic                          AddSub,
  output logic                          Done,
  output logic [1:0]                    Tstep,
  output logic [CNT_BITS-1:0]           InstrCount
);

  localparam int IW = OP_BITS + 2*SEL_BITS;

  step_t               r_step;
  step_t               w_step_nxt;
  logic [CNT_BITS-1:0] r_count;

  logic [OP_BITS-1:0]  w_op;
  logic [SEL_BITS-1:0] w_x;
  logic [SEL_BITS-1:0] w_y;
  logic [NUM_REGS-1:0] w_x_oh;
  logic [NUM_REGS-1:0] w_y_oh;

  // Which register field feeds which bus this step
  logic w_rin_x;
  logic w_rout_x;
  logic w_rout_y;
  logic w_done;

  assign w_op = Instrucao[IW-1 -: OP_BITS];
  assign w_x  = Instrucao[2*SEL_BITS-1 -: SEL_BITS];
  assign w_y  = Instrucao[SEL_BITS-1:0];

  decode_n_onehot #(.SEL_BITS(SEL_BITS), .NUM_REGS(NUM_REGS)) u_dec_x (
    .i_en     (w_rin_x | w_rout_x),
    .i_sel    (w_x),
    .o_onehot (w_x_oh)
  );

  decode_n_onehot #(.SEL_BITS(SEL_BITS), .NUM_REGS(NUM_REGS)) u_dec_y (
    .i_en     (w_rout_y),
    .i_sel    (w_y),
    .o_onehot (w_y_oh)
  );

  // State and retired-instruction counter
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_step  <= T0;
      r_count <= '0;
    end else begin
      r_step <= w_step_nxt;
      if (w_done) r_count <= r_count + CNT_BITS'(1);
    end
  end

  // Next-step and control decode
  always_comb begin
    w_step_nxt = r_step;
    IRin       = 1'b0;
    DINout     = 1'b0;
    Ain        = 1'b0;
    Gin        = 1'b0;
    Gout       = 1'b0;
    AddSub     = 1'b0;
    w_rin_x    = 1'b0;
    w_rout_x   = 1'b0;
    w_rout_y   = 1'b0;
    w_done     = 1'b0;

    case (r_step)
      T0: begin
        IRin       = Run;
        DINout     = Run;
        w_step_nxt = Run ? T1 : T0;
      end
      T1: begin
        if (w_op == OP_BITS'(OP_MV)) begin
          w_rout_y = 1'b1;
          w_rin_x  = 1'b1;
          w_done   = 1'b1;
        end else if (w_op == OP_BITS'(OP_MVI)) begin
          DINout   = 1'b1;
          w_rin_x  = 1'b1;
          w_done   = 1'b1;
        end else if (w_op == OP_BITS'(OP_ADD) || w_op == OP_BITS'(OP_SUB)) begin
          w_rout_x   = 1'b1;
          Ain        = 1'b1;
          w_step_nxt = T2;
        end else if (w_op == OP_BITS'(OP_MVNZ)) begin
          w_rout_y = GNZ;
          w_rin_x  = GNZ;
          w_done   = 1'b1;
        end else begin
          w_done = 1'b1;  // unassigned opcode: NOP
        end
      end
      T2: begin
        w_rout_y   = 1'b1;
        Gin        = 1'b1;
        AddSub     = (w_op == OP_BITS'(OP_SUB));
        w_step_nxt = T3;
      end
      T3: begin
        Gout    = 1'b1;
        w_rin_x = 1'b1;
        w_done  = 1'b1;
      end
      default: w_step_nxt = T0;
    endcase

    if (w_done) w_step_nxt = T0;
  end

  // X decoder feeds Rout only in add/sub T1, where it is the sole bus driver
  assign Rin        = w_rin_x  ? w_x_oh : '0;
  assign Rout       = w_rout_x ? w_x_oh : w_y_oh;
  assign Done       = w_done;
  assign Tstep      = r_step;
  assign InstrCount = r_count;

endmodule

// File: tb/tb_unidade_controle_fsm.sv
module tb_unidade_controle_fsm;

  // ---------------- clock / reset ----------------
  logic       Clock = 1'b0;
  logic       Resetn;
  logic       Resetn_s;
  logic       Run;
  logic [8:0] Instrucao;
  logic       GNZ;

  always #5 Clock = ~Clock;

  // main instance (defaults)
  logic        IRin, DINout, Ain, Gin, Gout, AddSub, Done;
  logic [7:0]  Rin, Rout;
  logic [1:0]  Tstep;
  logic [15:0] InstrCount;

  unidade_controle_fsm dut (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .Instrucao(Instrucao), .GNZ(GNZ),
    .IRin(IRin), .DINout(DINout), .Rin(Rin), .Rout(Rout), .Ain(Ain), .Gin(Gin),
    .Gout(Gout), .AddSub(AddSub), .Done(Done), .Tstep(Tstep), .InstrCount(InstrCount)
  );

  // small instance: 4 registers, 4-bit counter
  logic        IRin_s, DINout_s, Ain_s, Gin_s, Gout_s, AddSub_s, Done_s;
  logic [3:0]  Rin_s, Rout_s;
  logic [1:0]  Tstep_s;
  logic [3:0]  InstrCount_s;

  unidade_controle_fsm #(.NUM_REGS(4), .SEL_BITS(3), .OP_BITS(3), .CNT_BITS(4)) dut_s (
    .Clock(Clock), .Resetn(Resetn_s), .Run(Run), .Instrucao(Instrucao), .GNZ(GNZ),
    .IRin(IRin_s), .DINout(DINout_s), .Rin(Rin_s), .Rout(Rout_s), .Ain(Ain_s), .Gin(Gin_s),
    .Gout(Gout_s), .AddSub(AddSub_s), .Done(Done_s), .Tstep(Tstep_s), .InstrCount(InstrCount_s)
  );

  // ---------------- scoreboard ----------------
  logic [40:0] exp_q[$];
  string       tag_q[$];
  logic [20:0] exp_s_q[$];
  string       tag_s_q[$];
  int total = 0;
  int bad   = 0;
  int exp_cnt   = 0;
  int exp_cnt_s = 0;

  function automatic logic [40:0] mk(logic irin, logic dinout, logic [7:0] rin, logic [7:0] rout,
                                     logic ain, logic gin, logic gout, logic addsub, logic done,
                                     logic [1:0] ts, int cnt);
    return {irin, dinout, rin, rout, ain, gin, gout, addsub, done, ts, 16'(cnt)};
  endfunction

  function automatic logic [20:0] mks(logic irin, logic dinout, logic [3:0] rin, logic [3:0] rout,
                                      logic ain, logic gin, logic gout, logic addsub, logic done,
                                      logic [1:0] ts, int cnt);
    return {irin, dinout, rin, rout, ain, gin, gout, addsub, done, ts, 4'(cnt)};
  endfunction

  task automatic push_exp(string tag, logic [40:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic push_exp_s(string tag, logic [20:0] e);
    exp_s_q.push_back(e);
    tag_s_q.push_back(tag);
  endtask

  // Sample outputs 1 time unit after inputs were driven at the falling edge
  task automatic check();
    logic [40:0] e, o;
    logic [20:0] es, os;
    string t;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      o = {IRin, DINout, Rin, Rout, Ain, Gin, Gout, AddSub, Done, Tstep, InstrCount};
      total++;
      assert (o === e) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", t, o, e);
      end
    end
    while (exp_s_q.size() > 0) begin
      es = exp_s_q.pop_front();
      t  = tag_s_q.pop_front();
      os = {IRin_s, DINout_s, Rin_s, Rout_s, Ain_s, Gin_s, Gout_s, AddSub_s, Done_s, Tstep_s, InstrCount_s};
      total++;
      assert (os === es) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", t, os, es);
      end
    end
  endtask

  task automatic adv();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic tick();
    check();
    adv();
  endtask

  // idle T0 with Run=0: everything zero except the count
  task automatic idle(string tag);
    push_exp(tag, mk(0,0,8'h00,8'h00,0,0,0,0,0,2'd0,exp_cnt));
    tick();
  endtask

  task automatic fetch(string tag);
    push_exp(tag, mk(1,1,8'h00,8'h00,0,0,0,0,0,2'd0,exp_cnt));
    tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    Resetn = 1'b0; Resetn_s = 1'b0; Run = 1'b0; Instrucao = '0; GNZ = 1'b0;
    @(negedge Clock);
    idle("reset_state");
    Resetn = 1'b1;
    idle("idle_after_reset");

    // mv R2,R5 with Run dropped after fetch
    Run = 1'b1; Instrucao = 9'b000_010_101;
    fetch("mv_t0");
    Run = 1'b0;
    push_exp("mv_t1", mk(0,0,8'h04,8'h20,0,0,0,0,1,2'd1,exp_cnt));
    tick();
    exp_cnt++;
    idle("mv_retired");

    // add R1,R3 interrupted by reset in T2
    Run = 1'b1; Instrucao = 9'b010_001_011;
    fetch("add_rst_t0");
    Run = 1'b0;
    push_exp("add_rst_t1", mk(0,0,8'h00,8'h02,1,0,0,0,0,2'd1,exp_cnt));
    tick();
    push_exp("add_rst_t2", mk(0,0,8'h00,8'h08,0,1,0,0,0,2'd2,exp_cnt));
    check();
    #1 Resetn = 1'b0;
    exp_cnt = 0;
    push_exp("async_reset", mk(0,0,8'h00,8'h00,0,0,0,0,0,2'd0,exp_cnt));
    check();
    @(negedge Clock);
    Resetn = 1'b1;
    idle("release_idle0");
    idle("release_idle1");

    // add R1,R3 full
    Run = 1'b1; Instrucao = 9'b010_001_011;
    fetch("add_t0");
    Run = 1'b0;
    push_exp("add_t1", mk(0,0,8'h00,8'h02,1,0,0,0,0,2'd1,exp_cnt)); tick();
    push_exp("add_t2", mk(0,0,8'h00,8'h08,0,1,0,0,0,2'd2,exp_cnt)); tick();
    push_exp("add_t3", mk(0,0,8'h02,8'h00,0,0,1,0,1,2'd3,exp_cnt)); tick();
    exp_cnt++;
    idle("add_retired");

    // sub R1,R3
    Run = 1'b1; Instrucao = 9'b011_001_011;
    fetch("sub_t0");
    Run = 1'b0;
    push_exp("sub_t1", mk(0,0,8'h00,8'h02,1,0,0,0,0,2'd1,exp_cnt)); tick();
    push_exp("sub_t2", mk(0,0,8'h00,8'h08,0,1,0,1,0,2'd2,exp_cnt)); tick();
    push_exp("sub_t3", mk(0,0,8'h02,8'h00,0,0,1,0,1,2'd3,exp_cnt)); tick();
    exp_cnt++;
    idle("sub_retired");

    // mvnz R0,R7 with GNZ=0 then GNZ=1
    Run = 1'b1; Instrucao = 9'b110_000_111; GNZ = 1'b0;
    fetch("mvnz0_t0");
    Run = 1'b0;
    push_exp("mvnz0_t1", mk(0,0,8'h00,8'h00,0,0,0,0,1,2'd1,exp_cnt)); tick();
    exp_cnt++;
    idle("mvnz0_retired");
    Run = 1'b1; GNZ = 1'b1;
    fetch("mvnz1_t0");
    Run = 1'b0;
    push_exp("mvnz1_t1", mk(0,0,8'h01,8'h80,0,0,0,0,1,2'd1,exp_cnt)); tick();
    exp_cnt++;
    GNZ = 1'b0;
    idle("mvnz1_retired");

    // back-to-back: mvi R3, add R4,R4, NOP with Run held high
    Run = 1'b1; Instrucao = 9'b001_011_000;
    fetch("b2b_mvi_t0");
    push_exp("b2b_mvi_t1", mk(0,1,8'h08,8'h00,0,0,0,0,1,2'd1,exp_cnt)); tick();
    exp_cnt++;
    Instrucao = 9'b010_100_100;
    fetch("b2b_add_t0");
    push_exp("b2b_add_t1", mk(0,0,8'h00,8'h10,1,0,0,0,0,2'd1,exp_cnt)); tick();
    push_exp("b2b_add_t2", mk(0,0,8'h00,8'h10,0,1,0,0,0,2'd2,exp_cnt)); tick();
    push_exp("b2b_add_t3", mk(0,0,8'h10,8'h00,0,0,1,0,1,2'd3,exp_cnt)); tick();
    exp_cnt++;
    Instrucao = 9'b111_000_000;
    fetch("b2b_nop_t0");
    push_exp("b2b_nop_t1", mk(0,0,8'h00,8'h00,0,0,0,0,1,2'd1,exp_cnt)); tick();
    exp_cnt++;
    Run = 1'b0;
    idle("b2b_retired");

    // 16 back-to-back mv R1,R2 on both instances; small counter wraps
    Resetn_s = 1'b1;
    Run = 1'b1; Instrucao = 9'b000_001_010;
    for (int i = 0; i < 16; i++) begin
      push_exp("wrap_t0", mk(1,1,8'h00,8'h00,0,0,0,0,0,2'd0,exp_cnt));
      push_exp_s("wrap_s_t0", mks(1,1,4'h0,4'h0,0,0,0,0,0,2'd0,exp_cnt_s));
      tick();
      push_exp("wrap_t1", mk(0,0,8'h02,8'h04,0,0,0,0,1,2'd1,exp_cnt));
      push_exp_s("wrap_s_t1", mks(0,0,4'b0010,4'b0100,0,0,0,0,1,2'd1,exp_cnt_s));
      tick();
      exp_cnt++;
      exp_cnt_s = (exp_cnt_s + 1) % 16;
    end

    // mv R6,R1: R6 does not exist in the 4-register instance
    Instrucao = 9'b000_110_001;
    push_exp("mv61_t0", mk(1,1,8'h00,8'h00,0,0,0,0,0,2'd0,exp_cnt));
    push_exp_s("mv61_s_wrapped_t0", mks(1,1,4'h0,4'h0,0,0,0,0,0,2'd0,exp_cnt_s));
    tick();
    Run = 1'b0;
    push_exp("mv61_t1", mk(0,0,8'h40,8'h02,0,0,0,0,1,2'd1,exp_cnt));
    push_exp_s("mv61_s_t1", mks(0,0,4'h0,4'b0010,0,0,0,0,1,2'd1,exp_cnt_s));
    tick();
    exp_cnt++;
    exp_cnt_s = (exp_cnt_s + 1) % 16;
    push_exp_s("mv61_s_retired", mks(0,0,4'h0,4'h0,0,0,0,0,0,2'd0,exp_cnt_s));
    idle("final_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unidade_controle_fsm.md
Name: unidade_controle_fsm

Overview:
Parametrised successor of the processor control unit. It owns its own T-step state machine, so no external step counter is needed. It starts instructions only on Run and decodes IIIXXXYYY instructions for mv, mvi, add, sub and mvnz. It drives the datapath enables (register file, A, G, ALU, DIN mux) and counts retired instructions.

Parameters:
NUM_REGS, 8, number of general registers; width of the Rin/Rout one-hot buses.
SEL_BITS, 3, width of each register-select field (X, Y); NUM_REGS <= 2**SEL_BITS.
OP_BITS, 3, opcode field width.
CNT_BITS, 16, width of the retired-instruction counter.

Ports:
Clock  in  1  single system clock; all state updates on the rising edge.
Resetn  in  1  asynchronous, active-low reset.
Run  in  1  start request; sampled only in T0.
Instrucao  in  OP_BITS+2*SEL_BITS  IR contents; layout {opcode, X, Y}, MSB first; valid from T1 onward.
GNZ  in  1  G register non-zero flag from the datapath.
IRin  out  1  load IR.
DINout  out  1  drive DIN onto the bus.
Rin  out  NUM_REGS  one-hot register write enable.
Rout  out  NUM_REGS  one-hot register bus-drive enable.
Ain  out  1  load A.
Gin  out  1  load G.
Gout  out  1  drive G onto the bus.
AddSub  out  1  ALU mode: 0 = add, 1 = sub.
Done  out  1  last step of the current instruction.
Tstep  out  2  current step: 00=T0, 01=T1, 10=T2, 11=T3.
InstrCount  out  CNT_BITS  number of instructions retired.

Behaviour:
- Reset (async, Resetn=0): Tstep=T0, InstrCount=0. All outputs are combinational from state, so all of them read 0 while Run=0.
- Outputs are combinational from Tstep, Instrucao, Run and GNZ. Every control output defaults to 0 in every step. At most one bus driver (DINout, Gout, any Rout bit) is active in any cycle.
- T0 (fetch):
  - IRin = DINout = Run.
  - Run=1: next step is T1. Run=0: stay in T0 (idle).
- Opcodes:
  - 000 mv Rx,Ry. T1: Rout[Y]=1, Rin[X]=1, Done=1.
  - 001 mvi Rx,#D. T1: DINout=1, Rin[X]=1, Done=1. The immediate is on DIN during T1.
  - 010 add Rx,Ry.
    - T1: Rout[X]=1, Ain=1.
    - T2: Rout[Y]=1, Gin=1, AddSub=0.
    - T3: Gout=1, Rin[X]=1, Done=1.
  - 011 sub Rx,Ry: identical to add, except AddSub=1 in T2.
  - 110 mvnz Rx,Ry. T1: if GNZ=1, Rout[Y]=1 and Rin[X]=1. Done=1 regardless of GNZ.
  - 100, 101, 111: NOP. T1: Done=1 only, no other enable.
- Done=1 at a rising edge: next step is T0 and InstrCount increments, wrapping modulo 2**CNT_BITS.
- Run is ignored after T0. Dropping Run mid-instruction does not abort it.
- Run held high: back-to-back instructions with no idle cycle; T0 follows directly after Done.
- X or Y >= NUM_REGS: the corresponding one-hot bus is all zero. The step sequence and Done timing are unchanged.
- X == Y (e.g. add R2,R2): legal, follows the normal sequence.
- Resetn asserted mid-instruction: immediate return to T0. InstrCount clears; the partial instruction is not counted.
- Latency: mv/mvi/mvnz/NOP take 2 cycles including fetch; add/sub take 4.

Decomposition:
- Shared package: opcode constants (OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_MVNZ) and step encodings (T0..T3).
- One sub-module: decode_n_onehot, a parametrised SEL_BITS-to-NUM_REGS one-hot decoder with an enable input. It is instantiated twice, for X and Y.

Test Plan:
1. Resetn=0 mid add at T2 -> Tstep=00 immediately, InstrCount=0, all enables 0. Release Resetn with Run=0 -> stays in T0, IRin=0.
2. Run=1, then Instrucao=9'b000_010_101 (mv R2,R5) -> T0: IRin=DINout=1. T1: Rin=8'h04, Rout=8'h20, Done=1. Then T0, InstrCount=1.
3. Instrucao=9'b010_001_011 (add R1,R3) -> T1: Rout=8'h02, Ain=1. T2: Rout=8'h08, Gin=1, AddSub=0. T3: Gout=1, Rin=8'h02, Done=1. Repeat with 9'b011_001_011 -> AddSub=1 in T2.
4. mvnz 9'b110_000_111 with GNZ=0 -> T1: Rin=0, Rout=0, Done=1. Same instruction with GNZ=1 -> T1: Rin=8'h01, Rout=8'h80.
5. Run held high over mvi, add, NOP 9'b111_000_000 -> no idle cycles between instructions. NOP asserts only Done. InstrCount=3 after 2+4+2 = 8 cycles.
6. CNT_BITS=4, 16 back-to-back mv instructions -> InstrCount wraps 15->0. NUM_REGS=4 with mv R6,R1 -> Rin=0, Rout=4'b0010, Done=1.
